ctrl_fsm: RTL and testbench
===========================

Name: ctrl_fsm

Overview:
- Parametrised, multi-cycle successor to the KNIPS single-cycle control decoder.
- Sequences each instruction through fetch, execute and memory-wait.
- Holds a compare-flag register and drives PC-advance, jump, conditional-branch, register-write and memory strobes.
- Sits between the instruction ROM/fetch unit and the datapath (ALU, register file, data memory); supports memory with variable latency and a bounded wait.

Parameters:
IW, 9, instruction width (minimum OPW+2)
OPW, 5, opcode field width, Instruction[OPW-1:0]
OP_LBR, 5'h01, load opcode
OP_SBR, 5'h02, store opcode
OP_BR, 5'h03, conditional branch opcode; condition field Instruction[OPW+1:OPW]
OP_JMP, 5'h04, unconditional jump opcode
OP_CMP, 5'h05, compare opcode; captures flags, no register write
OP_HALT, 5'h1F, halt opcode
TIMEOUT, 8, maximum memory-wait cycles before fault (>=1)

Ports:
Clk  input  1  system clock, rising edge
Reset_n  input  1  asynchronous, active-low reset
Instruction  input  IW  machine code from instruction ROM
instr_valid  input  1  Instruction is valid this cycle
ZERO  input  1  ALU result == 0
BEVEN  input  1  ALU result[0] == 0
mem_ready  input  1  data memory has completed the access
instr_ack  output  1  instruction retired; fetch unit advances the PC
jump_en  output  1  take the unconditional jump target
branch_en  output  1  take the conditional branch target
reg_write  output  1  register file write enable
mem_read  output  1  data memory read strobe
mem_write  output  1  data memory write strobe
memToReg  output  1  register write-back source is memory
halted  output  1  core stopped (HALT or fault)
fault  output  1  memory timeout occurred

Behaviour:
- States: FETCH, EXEC, MEM, HALTED. Reset state is FETCH.
- On reset: all outputs 0; ir, flags zf/ef and wait counter cleared. Reset takes effect immediately, including in the middle of a MEM wait.
- All outputs are combinational functions of state, ir, flags and mem_ready. None is asserted in FETCH.
- FETCH: if instr_valid, ir <= Instruction and go to EXEC; otherwise stay.
- EXEC (exactly one cycle), decoded from ir opcode:
  - OP_CMP: zf <= ZERO, ef <= BEVEN; instr_ack=1; go to FETCH.
  - OP_BR: branch_en = condition met; instr_ack=1; go to FETCH. Condition codes: 00 always, 01 zf, 10 !zf, 11 ef.
  - OP_JMP: jump_en=1, instr_ack=1; go to FETCH.
  - OP_LBR: mem_read=1, memToReg=1; counter <= 0; go to MEM.
  - OP_SBR: mem_write=1; counter <= 0; go to MEM.
  - OP_HALT: go to HALTED.
  - Any other opcode (ALU op): reg_write=1, instr_ack=1; go to FETCH.
- MEM:
  - mem_read/memToReg (load) or mem_write (store) stay asserted every cycle.
  - When mem_ready=1: instr_ack=1, plus reg_write=1 for loads; go to FETCH.
  - When mem_ready=0: counter increments. When counter reaches TIMEOUT-1 with mem_ready=0, fault <= 1 and go to HALTED.
  - If mem_ready=1 in the timeout cycle, mem_ready wins: normal completion, no fault.
- HALTED: halted=1; fault holds its value. The state is sticky; only Reset_n exits it, and instr_valid is ignored.
- Flags update only on OP_CMP. A BR immediately following a CMP sees the new flags, because the flags are registered at the end of the CMP EXEC cycle.
- Counter width: clog2(TIMEOUT)+1 bits. It never wraps, because exit from MEM is forced at TIMEOUT-1.
- Minimum CPI: 2 for non-memory instructions; 3 + wait cycles for memory instructions.

Test Plan:
- Reset mid-MEM: LBR issued, Reset_n dropped on the 2nd wait cycle -> all outputs 0 asynchronously; state FETCH after release; reg_write never pulses.
- CMP with ZERO=1, then BR with cond=01 -> branch_en=1 in BR EXEC. Then CMP with ZERO=0, BR with cond=01 -> branch_en=0; BR with cond=10 -> branch_en=1.
- LBR with mem_ready arriving 3 cycles after EXEC -> mem_read and memToReg high for 4 cycles; reg_write and instr_ack high for exactly 1 cycle, in the ready cycle.
- SBR with mem_ready held 0, TIMEOUT=8 -> mem_write high through MEM; fault=1 and halted=1 after the 8th MEM cycle; both stay high until reset.
- SBR with mem_ready=1 exactly in the timeout cycle -> completes with instr_ack=1, fault stays 0.
- ALU op 5'h07 with instr_valid gaps of 2 cycles -> reg_write=1 and instr_ack=1 once per instruction. OP_HALT -> halted=1, and subsequent instr_valid is ignored.

Source files
------------

// File: rtl/ctrl_fsm_if.sv
// ctrl_fsm bus: instruction fetch, ALU flags,
// data memory handshake and datapath strobes.
interface ctrl_fsm_if #(
  parameter int IW = 9
);
  logic [IW-1:0] Instruction;
  logic          instr_valid;
  logic          ZERO;
  logic          BEVEN;
  logic          mem_ready;
  logic          instr_ack;
  logic          jump_en;
  logic          branch_en;
  logic          reg_write;
  logic          mem_read;
  logic          mem_write;
  logic          memToReg;
  logic          halted;
  logic          fault;

  modport master (
    input  Instruction, instr_valid,
    input  ZERO, BEVEN, mem_ready,
    output instr_ack, jump_en, branch_en,
    output reg_write, mem_read, mem_write,
    output memToReg, halted, fault
  );

  modport slave (
    output Instruction, instr_valid,
    output ZERO, BEVEN, mem_ready,
    input  instr_ack, jump_en, branch_en,
    input  reg_write, mem_read, mem_write,
    input  memToReg, halted, fault
  );
endinterface

// File: rtl/ctrl_fsm.sv
// Multi-cycle control sequencer: fetch, execute,
// memory wait with bounded timeout, sticky halt.
module ctrl_fsm #(
  parameter int IW = 9,
  parameter int OPW = 5,
  parameter logic [OPW-1:0] OP_LBR  = 5'h01,
  parameter logic [OPW-1:0] OP_SBR  = 5'h02,
  parameter logic [OPW-1:0] OP_BR   = 5'h03,
  parameter logic [OPW-1:0] OP_JMP  = 5'h04,
  parameter logic [OPW-1:0] OP_CMP  = 5'h05,
  parameter logic [OPW-1:0] OP_HALT = 5'h1F,
  parameter int TIMEOUT = 8
) (
  input logic Clk,
  input logic Reset_n,
  ctrl_fsm_if.master bus
);
  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    FETCH, EXEC, MEM, HALTED
  } state_t;

  state_t        state, state_d;
  logic [IW-1:0] ir, ir_d;
  logic          zf, zf_d;
  logic          ef, ef_d;
  logic          flt, flt_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [OPW-1:0] op;
  logic [1:0]    cc;
  logic          take;
  logic          is_ld;

  assign op    = ir[OPW-1:0];
  assign cc    = ir[OPW+1:OPW];
  assign is_ld = (op == OP_LBR);

  // Branch condition from the registered flags
  always_comb begin
    take = 1'b0;
    unique case (cc)
      2'b00: take = 1'b1;
      2'b01: take = zf;
      2'b10: take = ~zf;
      2'b11: take = ef;
      default: take = 1'b0;
    endcase
  end

  // State, ir, flags, counter and fault registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= FETCH;
      ir    <= '0;
      zf    <= 1'b0;
      ef    <= 1'b0;
      flt   <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_d;
      ir    <= ir_d;
      zf    <= zf_d;
      ef    <= ef_d;
      flt   <= flt_d;
      cnt   <= cnt_d;
    end
  end

  // Next-state and strobe decode
  always_comb begin
    state_d = state;
    ir_d    = ir;
    zf_d    = zf;
    ef_d    = ef;
    flt_d   = flt;
    cnt_d   = cnt;
    bus.instr_ack = 1'b0;
    bus.jump_en   = 1'b0;
    bus.branch_en = 1'b0;
    bus.reg_write = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.memToReg  = 1'b0;
    bus.halted    = 1'b0;
    bus.fault     = flt;
    unique case (state)
      FETCH: begin
        if (bus.instr_valid) begin
          ir_d    = bus.Instruction;
          state_d = EXEC;
        end
      end
      EXEC: begin
        unique case (1'b1)
          (op == OP_CMP): begin
            zf_d = bus.ZERO;
            ef_d = bus.BEVEN;
            bus.instr_ack = 1'b1;
            state_d = FETCH;
          end
          (op == OP_BR): begin
            bus.branch_en = take;
            bus.instr_ack = 1'b1;
            state_d = FETCH;
          end
          (op == OP_JMP): begin
            bus.jump_en   = 1'b1;
            bus.instr_ack = 1'b1;
            state_d = FETCH;
          end
          (op == OP_LBR): begin
            bus.mem_read = 1'b1;
            bus.memToReg = 1'b1;
            cnt_d   = '0;
            state_d = MEM;
          end
          (op == OP_SBR): begin
            bus.mem_write = 1'b1;
            cnt_d   = '0;
            state_d = MEM;
          end
          (op == OP_HALT): begin
            state_d = HALTED;
          end
          default: begin
            bus.reg_write = 1'b1;
            bus.instr_ack = 1'b1;
            state_d = FETCH;
          end
        endcase
      end
      MEM: begin
        bus.mem_read  = is_ld;
        bus.memToReg  = is_ld;
        bus.mem_write = ~is_ld;
        if (bus.mem_ready) begin
          bus.instr_ack = 1'b1;
          bus.reg_write = is_ld;
          state_d = FETCH;
        end else if (cnt == CNT_LAST) begin
          flt_d   = 1'b1;
          state_d = HALTED;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      HALTED: begin
        bus.halted = 1'b1;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end
endmodule

// File: tb/tb_ctrl_fsm.sv
// Randomized bench for ctrl_fsm against a
// per-instruction reference model.
module tb_ctrl_fsm;
  localparam int TO = 8;
  localparam logic [8:0] ACK = 9'h100;
  localparam logic [8:0] JMP = 9'h080;
  localparam logic [8:0] BRN = 9'h040;
  localparam logic [8:0] RW  = 9'h020;
  localparam logic [8:0] MR  = 9'h010;
  localparam logic [8:0] MW  = 9'h008;
  localparam logic [8:0] M2R = 9'h004;
  localparam logic [8:0] HLT = 9'h002;
  localparam logic [8:0] FLT = 9'h001;

  logic Clk = 1'b0;
  logic Reset_n;
  int   vec = 0;
  int   mis = 0;
  logic mzf, mef;
  logic mon = 1'b0;
  logic rw_seen = 1'b0;

  always #5 Clk = ~Clk;

  ctrl_fsm_if #(.IW(9)) bus ();

  ctrl_fsm #(.TIMEOUT(TO)) dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .bus(bus.master)
  );

  wire [8:0] obs = {
    bus.instr_ack, bus.jump_en, bus.branch_en,
    bus.reg_write, bus.mem_read, bus.mem_write,
    bus.memToReg, bus.halted, bus.fault
  };

  always @(posedge bus.reg_write)
    if (mon) rw_seen = 1'b1;

  function automatic logic [8:0] exp_exec(
    input logic [4:0] op, input logic [1:0] cc);
    logic taken;
    taken = (cc == 2'd0) || (cc == 2'd1 && mzf) ||
            (cc == 2'd2 && !mzf) || (cc == 2'd3 && mef);
    case (op)
      5'h05: return ACK;
      5'h03: return ACK | (taken ? BRN : 9'h0);
      5'h04: return ACK | JMP;
      5'h01: return MR | M2R;
      5'h02: return MW;
      5'h1F: return 9'h0;
      default: return ACK | RW;
    endcase
  endfunction

  function automatic logic [8:0] mk(
    input logic [4:0] op, input logic [1:0] cc);
    return {2'($urandom), cc, op};
  endfunction

  function automatic logic [4:0] alu_op();
    logic [4:0] op;
    do op = 5'($urandom_range(0, 31));
    while (op inside {5'h01, 5'h02, 5'h03,
                      5'h04, 5'h05, 5'h1F});
    return op;
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic issue(input logic [8:0] ins);
    bus.Instruction = ins;
    bus.instr_valid = 1'b1;
    step();
    bus.instr_valid = 1'b0;
    bus.Instruction = 9'($urandom);
  endtask

  task automatic test_reset();
    bus.Instruction = '0;
    bus.instr_valid = 1'b0;
    bus.ZERO = 1'b0;
    bus.BEVEN = 1'b0;
    bus.mem_ready = 1'b0;
    Reset_n = 1'b0;
    #3;
    vec++;
    if (obs !== 9'h0) begin
      mis++;
      $display("FAIL reset_outs got=%h exp=%h", obs, 9'h0);
    end
    step();
    step();
    Reset_n = 1'b1;
    mzf = 1'b0;
    mef = 1'b0;
    @(negedge Clk);
    vec++;
    if (obs !== 9'h0) begin
      mis++;
      $display("FAIL reset_idle got=%h exp=%h", obs, 9'h0);
    end
    step();
  endtask

  task automatic test_alu();
    logic [4:0] op;
    int gap;
    logic [8:0] e;
    for (int n = 0; n < 12; n++) begin
      op  = (n == 0) ? 5'h07 : alu_op();
      gap = (n < 2) ? 2 : $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(negedge Clk);
        vec++;
        if (obs !== 9'h0) begin
          mis++;
          $display("FAIL alu_gap got=%h exp=%h", obs, 9'h0);
        end
        step();
      end
      issue(mk(op, 2'($urandom)));
      @(negedge Clk);
      e = exp_exec(op, 2'b00);
      vec++;
      if (obs !== e) begin
        mis++;
        $display("FAIL alu_exec op=%h got=%h exp=%h",
                 op, obs, e);
      end
      step();
    end
  endtask

  task automatic test_flags();
    logic [4:0] ops[$];
    logic [1:0] ccs[$];
    logic       zs[$];
    logic       bs[$];
    logic [8:0] e;
    ops = '{5'h05, 5'h03, 5'h05, 5'h03, 5'h03};
    ccs = '{2'd0,  2'd1,  2'd0,  2'd1,  2'd2};
    zs  = '{1'b1,  1'b0,  1'b0,  1'b1,  1'b1};
    bs  = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b0};
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0, 1: ops.push_back(5'h05);
        2: ops.push_back(5'h04);
        3: ops.push_back(alu_op());
        default: ops.push_back(5'h03);
      endcase
      ccs.push_back(2'($urandom));
      zs.push_back(1'($urandom));
      bs.push_back(1'($urandom));
    end
    foreach (ops[i]) begin
      issue(mk(ops[i], ccs[i]));
      bus.ZERO  = zs[i];
      bus.BEVEN = bs[i];
      @(negedge Clk);
      e = exp_exec(ops[i], ccs[i]);
      vec++;
      if (obs !== e) begin
        mis++;
        $display("FAIL flag_seq i=%0d op=%h cc=%0d got=%h exp=%h",
                 i, ops[i], ccs[i], obs, e);
      end
      step();
      if (ops[i] == 5'h05) begin
        mzf = zs[i];
        mef = bs[i];
      end
      bus.ZERO  = 1'($urandom);
      bus.BEVEN = 1'($urandom);
    end
  endtask

  task automatic test_mem_access(input bit ld, input int d);
    logic [8:0] base;
    logic [8:0] e;
    base = ld ? (MR | M2R) : MW;
    issue(mk(ld ? 5'h01 : 5'h02, 2'($urandom)));
    bus.mem_ready = 1'($urandom);
    @(negedge Clk);
    vec++;
    if (obs !== base) begin
      mis++;
      $display("FAIL mem_exec ld=%0d got=%h exp=%h",
               ld, obs, base);
    end
    step();
    bus.mem_ready = 1'b0;
    for (int k = 0; k < d; k++) begin
      @(negedge Clk);
      vec++;
      if (obs !== base) begin
        mis++;
        $display("FAIL mem_wait ld=%0d k=%0d got=%h exp=%h",
                 ld, k, obs, base);
      end
      step();
    end
    bus.mem_ready = 1'b1;
    @(negedge Clk);
    e = base | ACK | (ld ? RW : 9'h0);
    vec++;
    if (obs !== e) begin
      mis++;
      $display("FAIL mem_done ld=%0d d=%0d got=%h exp=%h",
               ld, d, obs, e);
    end
    step();
    bus.mem_ready = 1'b0;
    @(negedge Clk);
    vec++;
    if (obs !== 9'h0) begin
      mis++;
      $display("FAIL mem_after ld=%0d got=%h exp=%h",
               ld, obs, 9'h0);
    end
    step();
  endtask

  task automatic test_reset_mid_mem();
    logic [8:0] e;
    rw_seen = 1'b0;
    mon = 1'b1;
    issue(mk(5'h01, 2'($urandom)));
    step();
    step();
    #2;
    Reset_n = 1'b0;
    #1;
    vec++;
    if (obs !== 9'h0) begin
      mis++;
      $display("FAIL rst_async got=%h exp=%h", obs, 9'h0);
    end
    step();
    Reset_n = 1'b1;
    mzf = 1'b0;
    mef = 1'b0;
    @(negedge Clk);
    vec++;
    if (obs !== 9'h0) begin
      mis++;
      $display("FAIL rst_release got=%h exp=%h", obs, 9'h0);
    end
    mon = 1'b0;
    vec++;
    if (rw_seen !== 1'b0) begin
      mis++;
      $display("FAIL rst_no_rw got=%b exp=0", rw_seen);
    end
    step();
    issue(mk(5'h07, 2'd0));
    @(negedge Clk);
    e = ACK | RW;
    vec++;
    if (obs !== e) begin
      mis++;
      $display("FAIL rst_refetch got=%h exp=%h", obs, e);
    end
    step();
  endtask

  task automatic test_timeout();
    issue(mk(5'h02, 2'($urandom)));
    @(negedge Clk);
    vec++;
    if (obs !== MW) begin
      mis++;
      $display("FAIL to_exec got=%h exp=%h", obs, MW);
    end
    step();
    for (int k = 0; k < TO; k++) begin
      @(negedge Clk);
      vec++;
      if (obs !== MW) begin
        mis++;
        $display("FAIL to_wait k=%0d got=%h exp=%h",
                 k, obs, MW);
      end
      step();
    end
    for (int k = 0; k < 4; k++) begin
      bus.instr_valid = 1'b1;
      bus.Instruction = mk(alu_op(), 2'd0);
      bus.mem_ready = 1'($urandom);
      @(negedge Clk);
      vec++;
      if (obs !== (HLT | FLT)) begin
        mis++;
        $display("FAIL to_fault k=%0d got=%h exp=%h",
                 k, obs, HLT | FLT);
      end
      step();
    end
    bus.instr_valid = 1'b0;
    bus.mem_ready = 1'b0;
    Reset_n = 1'b0;
    #1;
    vec++;
    if (obs !== 9'h0) begin
      mis++;
      $display("FAIL to_reset got=%h exp=%h", obs, 9'h0);
    end
    step();
    Reset_n = 1'b1;
    mzf = 1'b0;
    mef = 1'b0;
  endtask

  task automatic test_halt();
    issue(mk(5'h1F, 2'($urandom)));
    @(negedge Clk);
    vec++;
    if (obs !== 9'h0) begin
      mis++;
      $display("FAIL halt_exec got=%h exp=%h", obs, 9'h0);
    end
    step();
    for (int k = 0; k < 5; k++) begin
      bus.instr_valid = 1'b1;
      bus.Instruction = mk(alu_op(), 2'd0);
      bus.mem_ready = 1'($urandom);
      @(negedge Clk);
      vec++;
      if (obs !== HLT) begin
        mis++;
        $display("FAIL halt_sticky k=%0d got=%h exp=%h",
                 k, obs, HLT);
      end
      step();
    end
    bus.instr_valid = 1'b0;
    bus.mem_ready = 1'b0;
    Reset_n = 1'b0;
    step();
    Reset_n = 1'b1;
    mzf = 1'b0;
    mef = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu();
    test_flags();
    test_mem_access(1'b1, 3);
    test_mem_access(1'b0, TO - 1);
    test_mem_access(1'b1, TO - 1);
    test_mem_access(1'b0, 0);
    for (int i = 0; i < 8; i++)
      test_mem_access(1'($urandom),
                      $urandom_range(0, TO - 1));
    test_reset_mid_mem();
    test_flags();
    test_timeout();
    test_alu();
    test_halt();
    $display("== %0d vectors applied, %0d miscompares ==",
             vec, mis);
    $finish;
  end
endmodule
